// File: rtl/traffic_intersection_ctrl_if.sv
// Control/status bundle between the intersection controller and its lamp/request side.
// The master drives run-enable and pedestrian requests; the slave (controller) drives lamps and phase.
interface traffic_intersection_ctrl_if;
    logic       en;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output en, ped_req,
        input  ns_light, ew_light, walk, phase
    );

    modport slave (
        input  en, ped_req,
        output ns_light, ew_light, walk, phase
    );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Two-road (NS/EW) intersection light controller with all-red clearance and run/hold enable.
// Define TLC_PED_EN to add the pedestrian WALK phase after the second all-red.
module traffic_intersection_ctrl #(
    parameter int CNT_W       = 8,
    parameter int GREEN_TIME  = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_intersection_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        NS_G    = 3'd0,
        NS_Y    = 3'd1,
        AR1     = 3'd2,
        EW_G    = 3'd3,
        EW_Y    = 3'd4,
        AR2     = 3'd5,
        WALK    = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    state_t           state_q, state_d, succ;
    logic [CNT_W-1:0] cnt_q, cnt_d, last;
    logic             legal;
    logic             ped_go;

`ifdef TLC_PED_EN
    logic ped_pending_q, ped_pending_d;

    assign ped_go = ped_pending_q | bus.ped_req;
`else
    logic unused_ped_req;

    assign ped_go         = 1'b0;
    assign unused_ped_req = bus.ped_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NS_G;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TLC_PED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ped_pending_q <= 1'b0;
        else     ped_pending_q <= ped_pending_d;
    end

    // Requests are remembered until WALK is entered; requests made while walking are dropped.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_q != WALK && state_d == WALK) ped_pending_d = 1'b0;
        else if (state_q != WALK && bus.ped_req) ped_pending_d = 1'b1;
    end
`endif

    always_comb begin
        last = '0;
        case (state_q)
            NS_G, EW_G: last = CNT_W'(GREEN_TIME - 1);
            NS_Y, EW_Y: last = CNT_W'(YELLOW_TIME - 1);
            AR1, AR2:   last = CNT_W'(ALLRED_TIME - 1);
`ifdef TLC_PED_EN
            WALK:       last = CNT_W'(WALK_TIME - 1);
`endif
            default:    last = '0;
        endcase
    end

    // The dwell compare is made before the increment, so the counter can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        succ    = NS_G;
        legal   = 1'b1;
        case (state_q)
            NS_G:    succ = NS_Y;
            NS_Y:    succ = AR1;
            AR1:     succ = EW_G;
            EW_G:    succ = EW_Y;
            EW_Y:    succ = AR2;
            AR2:     succ = ped_go ? WALK : NS_G;
`ifdef TLC_PED_EN
            WALK:    succ = NS_G;
`endif
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            state_d = NS_G;
            cnt_d   = '0;
        end else if (bus.en) begin
            if (cnt_q == last) begin
                state_d = succ;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.ns_light = 3'b100;
        bus.ew_light = 3'b100;
        bus.walk     = 1'b0;
        bus.phase    = state_q;
        case (state_q)
            NS_G:    bus.ns_light = 3'b001;
            NS_Y:    bus.ns_light = 3'b010;
            EW_G:    bus.ew_light = 3'b001;
            EW_Y:    bus.ew_light = 3'b010;
`ifdef TLC_PED_EN
            WALK:    bus.walk = 1'b1;
`endif
            default: bus.ns_light = 3'b100;
        endcase
    end

endmodule
